// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and constants for the fetch/memory-stage SRAM-port arbiter.
package mem_req_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  // Owner tag stored per outstanding transaction.
  localparam logic REQ_INST = 1'b0;
  localparam logic REQ_DATA = 1'b1;

  typedef struct packed {
    logic              wr;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } sram_req_t;

  // Fetch requests are always reads with no strobes or write data.
  function automatic sram_req_t inst_to_req(input logic [ADDR_W-1:0] addr);
    sram_req_t r;
    r      = '0;
    r.addr = addr;
    return r;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_id_fifo.sv
// In-order owner-ID FIFO: 1-bit entries with occupancy count, full and empty.
module mem_req_arbiter_id_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     din,
  input  logic                     pop,
  output logic                     dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like memory port between fetch and memory stage; tracks
// outstanding owners in order and routes responses back to them.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned OUTST_DEPTH  = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         inst_req,
  input  logic [ADDR_W-1:0]            inst_addr,
  output logic                         inst_addr_ok,
  output logic                         inst_data_ok,
  output logic [DATA_W-1:0]            inst_rdata,
  input  logic                         data_req,
  input  logic                         data_wr,
  input  logic [STRB_W-1:0]            data_wstrb,
  input  logic [ADDR_W-1:0]            data_addr,
  input  logic [DATA_W-1:0]            data_wdata,
  output logic                         data_addr_ok,
  output logic                         data_data_ok,
  output logic [DATA_W-1:0]            data_rdata,
  output logic                         mem_req,
  output logic                         mem_wr,
  output logic [STRB_W-1:0]            mem_wstrb,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic                         mem_addr_ok,
  input  logic                         mem_data_ok,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic [$clog2(OUTST_DEPTH):0] outst_cnt,
  output logic                         resp_err
);

  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic          grant_c;
  logic          sel_req_c;
  sram_req_t     data_bus_c;
  sram_req_t     sel_bus_c;
  logic          push_c, pop_c;
  logic          fifo_full, fifo_empty, fifo_head;
  logic          lock_q, lock_d;
  logic          lock_grant_q, lock_grant_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          resp_err_q, resp_err_d;

  // Grant: held while locked, else starvation override, else data first.
  always_comb begin
    grant_c = REQ_INST;
    if (lock_q) begin
      grant_c = lock_grant_q;
    end else if (inst_req && (starve_cnt_q == SW'(STARVE_LIMIT))) begin
      grant_c = REQ_INST;
    end else if (data_req) begin
      grant_c = REQ_DATA;
    end
  end

  always_comb begin
    data_bus_c.wr    = data_wr;
    data_bus_c.wstrb = data_wstrb;
    data_bus_c.addr  = data_addr;
    data_bus_c.wdata = data_wdata;
    sel_bus_c        = (grant_c == REQ_DATA) ? data_bus_c : inst_to_req(inst_addr);
    sel_req_c        = (grant_c == REQ_DATA) ? data_req : inst_req;
  end

  // A full FIFO blocks the request even if a response pops this cycle.
  assign mem_req      = sel_req_c && !fifo_full && !reset;
  assign mem_wr       = sel_bus_c.wr;
  assign mem_wstrb    = sel_bus_c.wstrb;
  assign mem_addr     = sel_bus_c.addr;
  assign mem_wdata    = sel_bus_c.wdata;

  assign push_c       = mem_req && mem_addr_ok;
  assign inst_addr_ok = push_c && (grant_c == REQ_INST);
  assign data_addr_ok = push_c && (grant_c == REQ_DATA);

  assign pop_c        = mem_data_ok && !fifo_empty && !reset;
  assign inst_data_ok = pop_c && (fifo_head == REQ_INST);
  assign data_data_ok = pop_c && (fifo_head == REQ_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign resp_err     = resp_err_q;

  always_comb begin
    lock_d       = mem_req && !mem_addr_ok;
    lock_grant_d = lock_grant_q;
    if (mem_req && !mem_addr_ok) begin
      lock_grant_d = grant_c;
    end

    starve_cnt_d = starve_cnt_q;
    if (!inst_req || inst_addr_ok) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != SW'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end

    resp_err_d = resp_err_q || (mem_data_ok && fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q       <= 1'b0;
      lock_grant_q <= REQ_INST;
      starve_cnt_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      lock_grant_q <= lock_grant_d;
      starve_cnt_q <= starve_cnt_d;
      resp_err_q   <= resp_err_d;
    end
  end

  mem_req_arbiter_id_fifo #(
    .DEPTH (OUTST_DEPTH)
  ) u_id_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_c),
    .din   (grant_c),
    .pop   (pop_c),
    .dout  (fifo_head),
    .count (outst_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: inputs change at negedge, outputs
// are sampled 1ns later, well away from the active edge.
module tb_mem_req_arbiter;

  logic        clk;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic [2:0]  outst_cnt;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  mem_req_arbiter #(.OUTST_DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .outst_cnt(outst_cnt), .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    inst_req = 0; inst_addr = '0;
    data_req = 0; data_wr = 0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
  endtask

  // Pulse n responses; returns at the start of an idle cycle.
  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); mem_data_ok = 1; mem_rdata = 32'hD0D0_0000 + 32'(i);
    end
    @(negedge clk); mem_data_ok = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); idle_inputs(); reset = 1;
    inst_req = 1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1; mem_data_ok = 1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    checks++; if (inst_addr_ok !== 1'b0) begin errors++; $display("FAIL reset_addr_ok got %b exp 0", inst_addr_ok); end
    checks++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin errors++; $display("FAIL reset_data_ok got %b%b exp 00", inst_data_ok, data_data_ok); end
    @(negedge clk); idle_inputs(); reset = 0;
    #1;
    checks++; if (outst_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", outst_cnt); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got %b exp 0", resp_err); end
  endtask

  task automatic test_single_inst();
    @(negedge clk); inst_req = 1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1;
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h1C00_0000) begin errors++; $display("FAIL single_mem_req got %b %h exp 1 1c000000", mem_req, mem_addr); end
    checks++; if (mem_wr !== 1'b0 || mem_wstrb !== 4'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL single_inst_fields got %b %h %h exp 0 0 0", mem_wr, mem_wstrb, mem_wdata); end
    checks++; if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin errors++; $display("FAIL single_addr_ok got %b%b exp 10", inst_addr_ok, data_addr_ok); end
    @(negedge clk); inst_req = 0; mem_addr_ok = 0;
    #1;
    checks++; if (outst_cnt !== 3'd1) begin errors++; $display("FAIL single_cnt1 got %0d exp 1", outst_cnt); end
    @(negedge clk); mem_data_ok = 1; mem_rdata = 32'h0280_0C0C;
    #1;
    checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin errors++; $display("FAIL single_data_ok got %b%b exp 10", inst_data_ok, data_data_ok); end
    checks++; if (inst_rdata !== 32'h0280_0C0C) begin errors++; $display("FAIL single_rdata got %h exp 02800c0c", inst_rdata); end
    @(negedge clk); mem_data_ok = 0;
    #1;
    checks++; if (outst_cnt !== 3'd0) begin errors++; $display("FAIL single_cnt0 got %0d exp 0", outst_cnt); end
  endtask

  task automatic test_contention();
    @(negedge clk); inst_req = 1; inst_addr = 32'h1C00_0004;
    data_req = 1; data_wr = 0; data_addr = 32'h0000_1000; mem_addr_ok = 1;
    #1;
    checks++; if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0 || mem_addr !== 32'h1000) begin errors++; $display("FAIL cont_first got d%b i%b %h exp d1 i0 00001000", data_addr_ok, inst_addr_ok, mem_addr); end
    @(negedge clk); data_req = 0;
    #1;
    checks++; if (inst_addr_ok !== 1'b1 || mem_addr !== 32'h1C00_0004) begin errors++; $display("FAIL cont_second got i%b %h exp i1 1c000004", inst_addr_ok, mem_addr); end
    @(negedge clk); inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hAAAA_0001;
    #1;
    checks++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0 || data_rdata !== 32'hAAAA_0001) begin errors++; $display("FAIL cont_resp_a got d%b i%b %h exp d1 i0 aaaa0001", data_data_ok, inst_data_ok, data_rdata); end
    checks++; if (outst_cnt !== 3'd2) begin errors++; $display("FAIL cont_cnt2 got %0d exp 2", outst_cnt); end
    @(negedge clk); mem_rdata = 32'hBBBB_0002;
    #1;
    checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== 32'hBBBB_0002) begin errors++; $display("FAIL cont_resp_b got i%b d%b %h exp i1 d0 bbbb0002", inst_data_ok, data_data_ok, inst_rdata); end
    @(negedge clk); mem_data_ok = 0;
    #1;
    checks++; if (outst_cnt !== 3'd0) begin errors++; $display("FAIL cont_cnt0 got %0d exp 0", outst_cnt); end
  endtask

  task automatic test_lock();
    @(negedge clk); data_req = 1; data_wr = 1; data_wstrb = 4'hF; data_wdata = 32'h1234_5678;
    data_addr = 32'h1000; mem_addr_ok = 0;
    #1;
    checks++; if (mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_wstrb !== 4'hF || data_addr_ok !== 1'b0) begin errors++; $display("FAIL lock_start got r%b w%b s%h ok%b exp r1 w1 sf ok0", mem_req, mem_wr, mem_wstrb, data_addr_ok); end
    @(negedge clk); inst_req = 1; inst_addr = 32'h1C00_0008;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (mem_addr !== 32'h1000 || inst_addr_ok !== 1'b0) begin errors++; $display("FAIL lock_hold%0d got %h i%b exp 00001000 i0", c, mem_addr, inst_addr_ok); end
      @(negedge clk);
    end
    mem_addr_ok = 1;
    #1;
    checks++; if (data_addr_ok !== 1'b1 || mem_addr !== 32'h1000) begin errors++; $display("FAIL lock_accept got d%b %h exp d1 00001000", data_addr_ok, mem_addr); end
    @(negedge clk); data_req = 0;
    #1;
    checks++; if (inst_addr_ok !== 1'b1 || mem_addr !== 32'h1C00_0008) begin errors++; $display("FAIL lock_inst_after got i%b %h exp i1 1c000008", inst_addr_ok, mem_addr); end
    @(negedge clk); idle_inputs(); mem_data_ok = 1;
    #1;
    checks++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin errors++; $display("FAIL lock_store_done got d%b i%b exp d1 i0", data_data_ok, inst_data_ok); end
    drain(1);
    #1;
    checks++; if (outst_cnt !== 3'd0) begin errors++; $display("FAIL lock_cnt0 got %0d exp 0", outst_cnt); end
  endtask

  task automatic test_starvation();
    int hit;
    hit = -1;
    @(negedge clk); data_req = 1; data_wr = 0; data_wstrb = '0; data_addr = 32'h2000;
    inst_req = 1; inst_addr = 32'h1C00_000C; mem_addr_ok = 1;
    for (int c = 0; c < 6 && hit < 0; c++) begin
      #1;
      if (inst_addr_ok) hit = c;
      @(negedge clk);
    end
    idle_inputs();
    #1;
    checks++; if (hit !== 3) begin errors++; $display("FAIL starve_cycle got %0d exp 3", hit); end
    checks++; if (outst_cnt !== 3'd4) begin errors++; $display("FAIL starve_cnt got %0d exp 4", outst_cnt); end
    drain(4);
    #1;
    checks++; if (outst_cnt !== 3'd0) begin errors++; $display("FAIL starve_drain got %0d exp 0", outst_cnt); end
  endtask

  task automatic test_full();
    int acc;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); data_req = 1; data_wr = 0; data_addr = 32'h3000 + 32'(4 * i); mem_addr_ok = 1;
      #1;
      if (data_addr_ok) acc++;
    end
    checks++; if (acc !== 4) begin errors++; $display("FAIL full_fill got %0d exp 4", acc); end
    @(negedge clk); data_addr = 32'h3010;
    #1;
    checks++; if (mem_req !== 1'b0 || data_addr_ok !== 1'b0 || outst_cnt !== 3'd4) begin errors++; $display("FAIL full_block got r%b ok%b c%0d exp r0 ok0 c4", mem_req, data_addr_ok, outst_cnt); end
    @(negedge clk); mem_data_ok = 1;
    #1;
    checks++; if (mem_req !== 1'b0 || data_data_ok !== 1'b1 || outst_cnt !== 3'd4) begin errors++; $display("FAIL full_nobypass got r%b dok%b c%0d exp r0 dok1 c4", mem_req, data_data_ok, outst_cnt); end
    @(negedge clk); mem_data_ok = 0;
    #1;
    checks++; if (mem_req !== 1'b1 || data_addr_ok !== 1'b1 || outst_cnt !== 3'd3) begin errors++; $display("FAIL full_fifth got r%b ok%b c%0d exp r1 ok1 c3", mem_req, data_addr_ok, outst_cnt); end
    @(negedge clk); idle_inputs();
    #1;
    checks++; if (outst_cnt !== 3'd4) begin errors++; $display("FAIL full_cnt4 got %0d exp 4", outst_cnt); end
    drain(4);
  endtask

  task automatic test_reset_stray();
    @(negedge clk); inst_req = 1; inst_addr = 32'h1C00_0010; mem_addr_ok = 1;
    @(negedge clk); inst_addr = 32'h1C00_0014;
    @(negedge clk); idle_inputs();
    #1;
    checks++; if (outst_cnt !== 3'd2) begin errors++; $display("FAIL stray_pre got %0d exp 2", outst_cnt); end
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0; mem_data_ok = 1;
    #1;
    checks++; if (outst_cnt !== 3'd0 || resp_err !== 1'b0) begin errors++; $display("FAIL stray_after_reset got c%0d e%b exp c0 e0", outst_cnt, resp_err); end
    checks++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin errors++; $display("FAIL stray_no_ok got i%b d%b exp i0 d0", inst_data_ok, data_data_ok); end
    @(negedge clk); mem_data_ok = 0;
    #1;
    checks++; if (resp_err !== 1'b1 || outst_cnt !== 3'd0) begin errors++; $display("FAIL stray_err got e%b c%0d exp e1 c0", resp_err, outst_cnt); end
    @(negedge clk);
    #1;
    checks++; if (resp_err !== 1'b1) begin errors++; $display("FAIL stray_sticky got %b exp 1", resp_err); end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_single_inst();
    test_contention();
    test_lock();
    test_starvation();
    test_full();
    test_reset_stray();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
